// File: rtl/shared_ram_pkg.sv
// Shared types for the dual-core data RAM arbiter.
// Optional statistics are enabled with SHARED_RAM_STATS_EN.
package shared_ram_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_e;

   typedef logic port_t;

   localparam int unsigned AW_DEF = 8;
   localparam int unsigned DW_DEF = 32;

   // On a tie the port that did not win the previous tie goes next.
   function automatic port_t rr_pick(
      input logic  en0,
      input logic  en1,
      input port_t last
   );
      if (en0 && en1) return ~last;
      else if (en0)   return 1'b0;
      else            return 1'b1;
   endfunction

endpackage

// File: rtl/shared_ram_mem.sv
// Single-port word array: synchronous write, combinational read.
// No reset; contents are undefined until written.
module shared_ram_mem #(
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);

   logic [DW-1:0] mem_q [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= din;
   end

   assign dout = mem_q[addr];

endmodule

// File: rtl/shared_ram_arbiter.sv
// Round-robin arbiter giving two cores one shared single-port data RAM.
// Define SHARED_RAM_STATS_EN to add the conflict_cnt statistics port.
module shared_ram_arbiter
   import shared_ram_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ram_en_1,
   input  logic          ram_we_1,
   input  logic [AW-1:0] addr_1,
   input  logic [DW-1:0] ram_in_1,
   output logic [DW-1:0] ram_out_1,
   output logic          ram_ack_1,
   input  logic          ram_en_2,
   input  logic          ram_we_2,
   input  logic [AW-1:0] addr_2,
   input  logic [DW-1:0] ram_in_2,
   output logic [DW-1:0] ram_out_2,
   output logic          ram_ack_2
`ifdef SHARED_RAM_STATS_EN
   ,
   output logic [15:0]   conflict_cnt
`endif
);

   state_e        state_q, state_d;
   port_t         grant_q, grant_d;
   port_t         last_q, last_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] din_q, din_d;
   logic          ack1_q, ack1_d;
   logic          ack2_q, ack2_d;
   logic [DW-1:0] out1_q, out1_d;
   logic [DW-1:0] out2_q, out2_d;

   logic          both_en;
   port_t         pick;
   logic          mem_we;
   logic [DW-1:0] rdata;

   assign both_en = ram_en_1 & ram_en_2;
   assign pick    = rr_pick(ram_en_1, ram_en_2, last_q);

   // Gated by the live state so an async reset in ACCESS kills the write.
   assign mem_we  = (state_q == ACCESS) & we_q;

   shared_ram_mem #(
      .AW(AW),
      .DW(DW)
   ) u_mem (
      .clk (clk),
      .we  (mem_we),
      .addr(addr_q),
      .din (din_q),
      .dout(rdata)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      we_d    = we_q;
      addr_d  = addr_q;
      din_d   = din_q;
      ack1_d  = 1'b0;
      ack2_d  = 1'b0;
      out1_d  = out1_q;
      out2_d  = out2_q;
      unique case (state_q)
         IDLE: begin
            if (ram_en_1 || ram_en_2) begin
               state_d = ACCESS;
               grant_d = pick;
               if (both_en) last_d = pick;
               we_d    = pick ? ram_we_2 : ram_we_1;
               addr_d  = pick ? addr_2   : addr_1;
               din_d   = pick ? ram_in_2 : ram_in_1;
            end
         end
         ACCESS: begin
            state_d = ACK;
            ack1_d  = ~grant_q;
            ack2_d  = grant_q;
            if (!we_q) begin
               if (grant_q) out2_d = rdata;
               else         out1_d = rdata;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         ack1_q  <= 1'b0;
         ack2_q  <= 1'b0;
         out1_q  <= '0;
         out2_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         ack1_q  <= ack1_d;
         ack2_q  <= ack2_d;
         out1_q  <= out1_d;
         out2_q  <= out2_d;
      end
   end

   assign ram_ack_1 = ack1_q;
   assign ram_ack_2 = ack2_q;
   assign ram_out_1 = out1_q;
   assign ram_out_2 = out2_q;

`ifdef SHARED_RAM_STATS_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE && both_en && cnt_q != 16'hFFFF)
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Directed bench for shared_ram_arbiter: vector table plus
// hand-written contention and reset sequences.
module tb_shared_ram_arbiter;

   logic        clk;
   logic        rst;
   logic        ram_en_1, ram_we_1, ram_ack_1;
   logic [7:0]  addr_1;
   logic [31:0] ram_in_1, ram_out_1;
   logic        ram_en_2, ram_we_2, ram_ack_2;
   logic [7:0]  addr_2;
   logic [31:0] ram_in_2, ram_out_2;
`ifdef SHARED_RAM_STATS_EN
   logic [15:0] conflict_cnt;
`endif

   int n_vec = 0;
   int n_bad = 0;

   shared_ram_arbiter #(.AW(8), .DW(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .ram_en_1 (ram_en_1),
      .ram_we_1 (ram_we_1),
      .addr_1   (addr_1),
      .ram_in_1 (ram_in_1),
      .ram_out_1(ram_out_1),
      .ram_ack_1(ram_ack_1),
      .ram_en_2 (ram_en_2),
      .ram_we_2 (ram_we_2),
      .addr_2   (addr_2),
      .ram_in_2 (ram_in_2),
      .ram_out_2(ram_out_2),
      .ram_ack_2(ram_ack_2)
`ifdef SHARED_RAM_STATS_EN
      ,
      .conflict_cnt(conflict_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit          p;
      bit          we;
      logic [7:0]  a;
      logic [31:0] d;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   vec_t vt [9];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_req(input bit p, input bit en, input bit we,
                          input logic [7:0] a, input logic [31:0] d);
      if (!p) begin
         ram_en_1 = en; ram_we_1 = we; addr_1 = a; ram_in_1 = d;
      end else begin
         ram_en_2 = en; ram_we_2 = we; addr_2 = a; ram_in_2 = d;
      end
   endtask

   // Called just after a falling edge with the arbiter in IDLE.
   task automatic txn(input bit p, input bit we, input logic [7:0] a,
                      input logic [31:0] d, input logic [31:0] e1,
                      input logic [31:0] e2, input string tag);
      int  cyc;
      bit  got;
      cyc = 0;
      got = 1'b0;
      set_req(p, 1'b1, we, a, d);
      while (!got && cyc < 8) begin
         @(negedge clk);
         cyc++;
         if (p ? ram_ack_2 : ram_ack_1) got = 1'b1;
      end
      chk({tag, "_lat"}, got ? cyc : 99, 2);
      chk({tag, "_other_ack"}, p ? ram_ack_1 : ram_ack_2, 0);
      chk({tag, "_out1"}, ram_out_1, e1);
      chk({tag, "_out2"}, ram_out_2, e2);
      set_req(p, 1'b0, 1'b0, 8'h00, 32'h0);
      @(negedge clk);
      chk({tag, "_ack_pulse"}, p ? ram_ack_2 : ram_ack_1, 0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      set_req(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      set_req(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int c1, c2, n1, n2, k;
      int ord [4];
      int at  [4];
      int exp_ord [4];
      int exp_at  [4];

      vt[0] = '{0, 1, 8'h10, 32'hDEADBEEF, 32'h0,        32'h0};
      vt[1] = '{0, 0, 8'h10, 32'h0,        32'hDEADBEEF, 32'h0};
      vt[2] = '{1, 1, 8'hFF, 32'h00000055, 32'hDEADBEEF, 32'h0};
      vt[3] = '{0, 0, 8'hFF, 32'h0,        32'h00000055, 32'h0};
      vt[4] = '{1, 0, 8'h10, 32'h0,        32'h00000055, 32'hDEADBEEF};
      vt[5] = '{1, 1, 8'h00, 32'hA5A5A5A5, 32'h00000055, 32'hDEADBEEF};
      vt[6] = '{0, 0, 8'h00, 32'h0,        32'hA5A5A5A5, 32'hDEADBEEF};
      vt[7] = '{0, 1, 8'h20, 32'hCAFEF00D, 32'hA5A5A5A5, 32'hDEADBEEF};
      vt[8] = '{1, 0, 8'h20, 32'h0,        32'hA5A5A5A5, 32'hCAFEF00D};

      exp_ord = '{0, 1, 0, 1};
      exp_at  = '{2, 5, 8, 11};

      // Reset state
      do_reset();
      chk("rst_ack1", ram_ack_1, 0);
      chk("rst_ack2", ram_ack_2, 0);
      chk("rst_out1", ram_out_1, 0);
      chk("rst_out2", ram_out_2, 0);
`ifdef SHARED_RAM_STATS_EN
      chk("rst_cnt", conflict_cnt, 0);
`endif
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         txn(vt[i].p, vt[i].we, vt[i].a, vt[i].d,
             vt[i].e1, vt[i].e2, $sformatf("vec%0d", i));
      end

      // Simultaneous first tie: port 0 wins, port 1 served next
      c1 = 0;
      c2 = 0;
      set_req(1'b0, 1'b1, 1'b0, 8'h10, 32'h0);
      set_req(1'b1, 1'b1, 1'b0, 8'hFF, 32'h0);
      for (int cyc = 1; cyc <= 12 && (c1 == 0 || c2 == 0); cyc++) begin
         @(negedge clk);
         if (ram_ack_1) begin
            c1 = cyc;
            chk("simul_rd1", ram_out_1, 32'hDEADBEEF);
            ram_en_1 = 1'b0;
         end
         if (ram_ack_2) begin
            c2 = cyc;
            chk("simul_rd2", ram_out_2, 32'h00000055);
            ram_en_2 = 1'b0;
         end
      end
      chk("simul_ack1_cyc", c1, 2);
      chk("simul_ack2_cyc", c2, 5);
      @(negedge clk);

      // Sustained contention, two transactions per port
      do_reset();
      n1 = 0;
      n2 = 0;
      k  = 0;
      ord = '{default: -1};
      at  = '{default: -1};
      set_req(1'b0, 1'b1, 1'b0, 8'h10, 32'h0);
      set_req(1'b1, 1'b1, 1'b0, 8'hFF, 32'h0);
      for (int cyc = 1; cyc <= 30 && k < 4; cyc++) begin
         @(negedge clk);
         if (ram_ack_1) begin
            if (k < 4) begin ord[k] = 0; at[k] = cyc; end
            k++;
            n1++;
            if (n1 == 2) ram_en_1 = 1'b0;
         end
         if (ram_ack_2) begin
            if (k < 4) begin ord[k] = 1; at[k] = cyc; end
            k++;
            n2++;
            if (n2 == 2) ram_en_2 = 1'b0;
         end
      end
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rr_grant%0d", i), ord[i], exp_ord[i]);
         chk($sformatf("rr_ackcyc%0d", i), at[i], exp_at[i]);
      end
`ifdef SHARED_RAM_STATS_EN
      chk("conflict_cnt", conflict_cnt, 3);
`endif
      @(negedge clk);

      // Reset during ACK drops the ack at once
      set_req(1'b0, 1'b1, 1'b0, 8'h20, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("ackrst_pre", ram_ack_1, 1);
      rst = 1'b0;
      ram_en_1 = 1'b0;
      #1;
      chk("ackrst_ack", ram_ack_1, 0);
      chk("ackrst_out", ram_out_1, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Reset during ACCESS suppresses the write and the ack
      set_req(1'b0, 1'b1, 1'b1, 8'h20, 32'h12345678);
      @(negedge clk);
      chk("midrst_no_early_ack", ram_ack_1, 0);
      rst = 1'b0;
      set_req(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("midrst_ack%0d", i), ram_ack_1, 0);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_idle_ack", ram_ack_1, 0);
      txn(1'b0, 1'b0, 8'h20, 32'h0, 32'hCAFEF00D, 32'h0, "midrst_rd");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
